// File: rtl/match_pkg.sv
// Shared types and helpers for the colour-matching game sequencer:
// FSM encoding, field widths, colour codes, complement-pair rule and LFSR taps.
package match_pkg;

  localparam int STATE_W = 3;
  localparam int COLOR_W = 3;
  localparam int CNT_W   = 4;
  localparam int LFSR_W  = 8;

  // x^8 + x^6 + x^5 + x^4 + 1 as a Fibonacci left-shift register: bits 7,5,4,3
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_SHOW     = 3'd1,
    ST_WAIT_SEL = 3'd2,
    ST_CHECK    = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  localparam logic [COLOR_W-1:0] COL_0 = 3'd0;
  localparam logic [COLOR_W-1:0] COL_1 = 3'd1;
  localparam logic [COLOR_W-1:0] COL_2 = 3'd2;
  localparam logic [COLOR_W-1:0] COL_3 = 3'd3;
  localparam logic [COLOR_W-1:0] COL_4 = 3'd4;
  localparam logic [COLOR_W-1:0] COL_5 = 3'd5;
  localparam logic [COLOR_W-1:0] COL_6 = 3'd6;
  localparam logic [COLOR_W-1:0] COL_7 = 3'd7;

  // Each colour has exactly one partner, so the unordered pair check reduces
  // to a partner lookup; no colour is its own partner.
  function automatic logic is_pair(input logic [COLOR_W-1:0] a,
                                   input logic [COLOR_W-1:0] b);
    logic [COLOR_W-1:0] p;
    case (a)
      COL_0:   p = COL_6;
      COL_6:   p = COL_0;
      COL_1:   p = COL_4;
      COL_4:   p = COL_1;
      COL_2:   p = COL_3;
      COL_3:   p = COL_2;
      COL_5:   p = COL_7;
      COL_7:   p = COL_5;
      default: p = COL_0;
    endcase
    return (b == p);
  endfunction

endpackage

// File: rtl/match_round_ctrl_btn.sv
// btn_conditioner: 2-FF synchroniser, debounce counter and press-event pulse.
// btn_evt is a one-cycle pulse on each accepted press; releases are silent.
module btn_conditioner #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic btn_evt
);

  localparam int CW = $clog2(DEB_CYCLES);

  logic          s1;
  logic          s2;
  logic          deb;
  logic          deb_d;
  logic          deb_d2;
  logic [CW-1:0] cnt;

  if (DEB_CYCLES < 2) begin : g_bad_deb
    $error("btn_conditioner: DEB_CYCLES must be at least 2");
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      deb     <= 1'b0;
      deb_d   <= 1'b0;
      deb_d2  <= 1'b0;
      cnt     <= '0;
      btn_evt <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      if (s2 != deb) begin
        if (cnt == CW'(DEB_CYCLES - 1)) begin
          deb <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
      // Edge detect on the retimed debounced level; only rising edges count.
      deb_d   <= deb;
      deb_d2  <= deb_d;
      btn_evt <= deb_d & ~deb_d2;
    end
  end

endmodule

// File: rtl/match_round_ctrl.sv
// Colour-matching game sequencer: debounced button steps a single-clock round FSM.
// Optional WAIT_SEL timeout is enabled by defining MATCH_TIMEOUT_EN.
module match_round_ctrl
  import match_pkg::*;
#(
  parameter int          ROUNDS         = 3,
  parameter int          DEB_CYCLES     = 16,
  parameter int          TIMEOUT_CYCLES = 1000,
  parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn,
  input  logic [COLOR_W-1:0] sel,
  output logic [COLOR_W-1:0] target,
  output logic [CNT_W-1:0]   round,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   score,
  output logic [CNT_W-1:0]   misses,
  output logic               match_ok,
  output logic               miss,
  output logic               game_done
);

  localparam logic [CNT_W-1:0] ROUND_LAST = CNT_W'(ROUNDS - 1);

  if (ROUNDS < 1 || ROUNDS > 15 || TIMEOUT_CYCLES < 1 || LFSR_SEED == 8'h00) begin : g_bad_cfg
    $error("match_round_ctrl: illegal ROUNDS, TIMEOUT_CYCLES or LFSR_SEED");
  end

  state_t             st;
  state_t             st_n;
  logic               btn_evt;
  logic [LFSR_W-1:0]  lfsr;
  logic [COLOR_W-1:0] sel_q;
  logic [COLOR_W-1:0] sel_q_n;
  logic [COLOR_W-1:0] target_n;
  logic [CNT_W-1:0]   round_n;
  logic [CNT_W-1:0]   score_n;
  logic [CNT_W-1:0]   misses_n;
  logic [CNT_W-1:0]   misses_inc;
  logic               match_ok_n;
  logic               miss_n;
  logic               last_round;

  btn_conditioner #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_btn (
    .clk     (clk),
    .rst     (rst),
    .btn     (btn),
    .btn_evt (btn_evt)
  );

  assign misses_inc = (misses == 4'hF) ? misses : misses + 4'd1;
  assign last_round = (round == ROUND_LAST);
  assign state      = st;
  assign game_done  = (st == ST_DONE);

`ifdef MATCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;

  assign tmo_hit = (st == ST_WAIT_SEL) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Held at zero outside WAIT_SEL so every entry starts a fresh attempt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (st == ST_WAIT_SEL && st_n == ST_WAIT_SEL) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end
`endif

  always_comb begin
    st_n       = st;
    target_n   = target;
    round_n    = round;
    score_n    = score;
    misses_n   = misses;
    sel_q_n    = sel_q;
    match_ok_n = 1'b0;
    miss_n     = 1'b0;
    case (st)
      ST_IDLE: begin
        if (btn_evt) begin
          score_n  = '0;
          misses_n = '0;
          round_n  = '0;
          st_n     = ST_SHOW;
        end
      end
      ST_SHOW: begin
        target_n = lfsr[COLOR_W-1:0];
        st_n     = ST_WAIT_SEL;
      end
      ST_WAIT_SEL: begin
        if (btn_evt) begin
          sel_q_n = sel;
          st_n    = ST_CHECK;
        end
`ifdef MATCH_TIMEOUT_EN
        else if (tmo_hit) begin
          // A timeout advances the round like a match, without scoring.
          miss_n   = 1'b1;
          misses_n = misses_inc;
          if (last_round) begin
            st_n = ST_DONE;
          end else begin
            round_n = round + 4'd1;
            st_n    = ST_SHOW;
          end
        end
`endif
      end
      ST_CHECK: begin
        if (is_pair(target, sel_q)) begin
          match_ok_n = 1'b1;
          score_n    = score + 4'd1;
          if (last_round) begin
            st_n = ST_DONE;
          end else begin
            round_n = round + 4'd1;
            st_n    = ST_SHOW;
          end
        end else begin
          miss_n   = 1'b1;
          misses_n = misses_inc;
          st_n     = ST_WAIT_SEL;
        end
      end
      ST_DONE: begin
        if (btn_evt) begin
          st_n = ST_IDLE;
        end
      end
      default: st_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= ST_IDLE;
      target   <= '0;
      round    <= '0;
      score    <= '0;
      misses   <= '0;
      sel_q    <= '0;
      match_ok <= 1'b0;
      miss     <= 1'b0;
      lfsr     <= LFSR_SEED;
    end else begin
      st       <= st_n;
      target   <= target_n;
      round    <= round_n;
      score    <= score_n;
      misses   <= misses_n;
      sel_q    <= sel_q_n;
      match_ok <= match_ok_n;
      miss     <= miss_n;
      // Free-running in every state so the drawn colour depends on press timing.
      lfsr     <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
    end
  end

endmodule
